// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared scan-controller types: slot states, anode polarity,
//               counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } seg7_state_e;

    localparam logic AN_OFF = 1'b1;
    localparam logic AN_ON  = 1'b0;

    // Bits needed to count 0..cycles-1, never less than one.
    function automatic int seg7_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_slot_timer.sv
`default_nettype none
// ============================================================================
// Module      : seg7_slot_timer
// Description : Slot counter with BLANK/SHOW sequencing and digit index;
//               frame_wrap marks the last cycle of the last digit slot.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_slot_timer
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SLOT_CYC   = 50000,
    parameter int BLANK_CYC  = 64,
    parameter int IDX_W      = seg7_cnt_width(NUM_DIGITS)
) (
    input  logic              clk,
    input  logic              rst,
    output seg7_state_e       o_state,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_frame_wrap
);

    localparam int                c_cnt_w      = seg7_cnt_width(SLOT_CYC);
    localparam logic [c_cnt_w-1:0] c_slot_last  = c_cnt_w'(SLOT_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [IDX_W-1:0]   c_idx_last   = IDX_W'(NUM_DIGITS - 1);
    // Without blanking every slot starts directly in SHOW.
    localparam seg7_state_e        c_slot_first = (BLANK_CYC > 0) ? ST_BLANK : ST_SHOW;

    seg7_state_e          r_state;
    seg7_state_e          w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic                 w_slot_end;

    assign w_slot_end = (r_cnt == c_slot_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_slot_first;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_slot_end ? '0 : r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        if (w_slot_end) begin
            w_idx_nxt = (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
        end
        case (r_state)
            ST_BLANK: if (r_cnt == c_blank_last) w_state_nxt = ST_SHOW;
            ST_SHOW:  if (w_slot_end)            w_state_nxt = c_slot_first;
            default:                             w_state_nxt = c_slot_first;
        endcase
    end

    assign o_state      = r_state;
    assign o_idx        = r_idx;
    assign o_frame_wrap = w_slot_end && (r_idx == c_idx_last);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_ctrl
// Description : Multiplexed 7-segment scan controller with double-buffered
//               frames; SEG7_LZB_EN adds leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SLOT_CYC   = 50000,
    parameter int BLANK_CYC  = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic [NUM_DIGITS-1:0]   wr_dp,
    input  logic                    disp_en,
    output logic [3:0]              dig_val,
    output logic                    dig_dp,
    output logic                    dig_en,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_start
);

    localparam int c_idx_w = seg7_cnt_width(NUM_DIGITS);

    seg7_state_e                  w_state;
    logic [c_idx_w-1:0]           w_idx;
    logic                         w_frame_wrap;

    logic [NUM_DIGITS-1:0][3:0]   r_shadow_val;
    logic [NUM_DIGITS-1:0][3:0]   r_active_val;
    logic [NUM_DIGITS-1:0]        r_shadow_dp;
    logic [NUM_DIGITS-1:0]        r_active_dp;
    logic                         r_wr_ready;
    logic                         r_new_frame;
    logic                         w_wr_fire;
    logic                         w_commit;
    logic                         w_hide;
    logic                         w_show;
    logic [NUM_DIGITS-1:0]        w_an_nxt;

    seg7_slot_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SLOT_CYC   (SLOT_CYC),
        .BLANK_CYC  (BLANK_CYC),
        .IDX_W      (c_idx_w)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .o_state      (w_state),
        .o_idx        (w_idx),
        .o_frame_wrap (w_frame_wrap)
    );

    // wr_ready doubles as the inverted pending flag, so fire and commit are exclusive.
    assign w_wr_fire = wr_valid && r_wr_ready;
    assign w_commit  = w_frame_wrap && !r_wr_ready;
    assign wr_ready  = r_wr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_active_val <= '0;
            r_active_dp  <= '0;
            r_wr_ready   <= 1'b1;
        end else if (w_wr_fire) begin
            r_shadow_val <= wr_data;
            r_shadow_dp  <= wr_dp;
            r_wr_ready   <= 1'b0;
        end else if (w_commit) begin
            r_active_val <= r_shadow_val;
            r_active_dp  <= r_shadow_dp;
            r_wr_ready   <= 1'b1;
        end
    end

`ifdef SEG7_LZB_EN
    logic [NUM_DIGITS-1:0] r_lzb_mask;
    logic [NUM_DIGITS-1:0] w_lzb_nxt;
    logic                  w_lzb_run;

    // A digit is hidden when it and everything above it is a blank zero.
    always_comb begin
        w_lzb_nxt = '0;
        w_lzb_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_lzb_run    = w_lzb_run && (r_shadow_val[i] == 4'h0) && !r_shadow_dp[i];
            w_lzb_nxt[i] = w_lzb_run;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lzb_mask <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
        end else if (w_commit) begin
            r_lzb_mask <= w_lzb_nxt;
        end
    end

    assign w_hide = r_lzb_mask[w_idx];
`else
    assign w_hide = 1'b0;
`endif

    assign w_show = (w_state == ST_SHOW) && disp_en && !w_hide;

    always_comb begin
        w_an_nxt = {NUM_DIGITS{AN_OFF}};
        if (w_show) begin
            w_an_nxt[w_idx] = AN_ON;
        end
    end

    // r_new_frame is high during the first timer cycle of digit 0, including after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_n        <= {NUM_DIGITS{AN_OFF}};
            dig_en      <= 1'b0;
            dig_val     <= 4'h0;
            dig_dp      <= 1'b0;
            frame_start <= 1'b0;
            r_new_frame <= 1'b1;
        end else begin
            an_n        <= w_an_nxt;
            dig_en      <= w_show;
            dig_val     <= r_active_val[w_idx];
            dig_dp      <= r_active_dp[w_idx];
            frame_start <= r_new_frame;
            r_new_frame <= w_frame_wrap;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_ctrl
// Description : Scoreboard bench for seg7_scan_ctrl (4 digits, 8-cycle slots,
//               2-cycle blanking) against a frame-position reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int ND    = 4;
    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = ND * SLOT;
`ifdef SEG7_LZB_EN
    localparam bit LZB_ON = 1'b1;
`else
    localparam bit LZB_ON = 1'b0;
`endif

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          wr_valid = 1'b0;
    logic [15:0]   wr_data  = '0;
    logic [3:0]    wr_dp    = '0;
    logic          disp_en  = 1'b1;
    logic          wr_ready;
    logic [3:0]    dig_val;
    logic          dig_dp;
    logic          dig_en;
    logic [3:0]    an_n;
    logic          frame_start;

    seg7_scan_ctrl #(
        .NUM_DIGITS (ND),
        .SLOT_CYC   (SLOT),
        .BLANK_CYC  (BLANK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .wr_dp       (wr_dp),
        .disp_en     (disp_en),
        .dig_val     (dig_val),
        .dig_dp      (dig_dp),
        .dig_en      (dig_en),
        .an_n        (an_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an_n;
        logic       en;
        logic [3:0] val;
        logic       dp;
        logic       fs;
        logic       rdy;
    } exp_t;

    exp_t        exp_q[$];
    int          m_t;
    logic [15:0] m_act, m_shd;
    logic [3:0]  m_act_dp, m_shd_dp;
    bit          m_pend;
    bit          m_started = 1'b0;
    int          n_checks  = 0;
    int          n_fail    = 0;

    function automatic bit lz_hidden(int d, logic [15:0] v, logic [3:0] dp);
        bit all_zero;
        all_zero = (d > 0);
        for (int j = d; j < ND; j++) begin
            if (v[4*j +: 4] != 4'h0 || dp[j]) all_zero = 1'b0;
        end
        return LZB_ON && all_zero;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: actual %h required %h", name, $time, act, req);
        end
    endtask

    // Reference model: frame position from cycles since reset decides the output.
    task automatic model_step();
        exp_t e;
        int   p, d, c;
        bit   show;
        if (rst) begin
            m_started = 1'b1;
            m_t = 0; m_act = '0; m_shd = '0; m_act_dp = '0; m_shd_dp = '0; m_pend = 1'b0;
            e.an_n = 4'hF; e.en = 1'b0; e.val = 4'h0; e.dp = 1'b0; e.fs = 1'b0; e.rdy = 1'b1;
            exp_q.push_back(e);
        end else if (m_started) begin
            p = m_t % FRAME;
            d = p / SLOT;
            c = p % SLOT;
            show   = (c >= BLANK) && disp_en && !lz_hidden(d, m_act, m_act_dp);
            e.an_n = show ? ~(4'b0001 << d) : 4'hF;
            e.en   = show;
            e.val  = m_act[4*d +: 4];
            e.dp   = m_act_dp[d];
            e.fs   = (p == 0);
            if (p == FRAME - 1 && m_pend) begin
                m_act = m_shd; m_act_dp = m_shd_dp; m_pend = 1'b0;
            end else if (wr_valid && !m_pend) begin
                m_shd = wr_data; m_shd_dp = wr_dp; m_pend = 1'b1;
            end
            e.rdy = !m_pend;
            exp_q.push_back(e);
            m_t++;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("an_n",        {4'h0, an_n},        {4'h0, e.an_n});
                check("dig_en",      {7'h0, dig_en},      {7'h0, e.en});
                check("frame_start", {7'h0, frame_start}, {7'h0, e.fs});
                check("wr_ready",    {7'h0, wr_ready},    {7'h0, e.rdy});
                if (e.en) begin
                    check("dig_val", {4'h0, dig_val}, {4'h0, e.val});
                    check("dig_dp",  {7'h0, dig_dp},  {7'h0, e.dp});
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait until the next rising edge lands on frame position p.
    task automatic wait_pos(input int p);
        int guard = 0;
        while ((m_t % FRAME) != p && guard < 2 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (guard >= 2 * FRAME) begin
            n_fail++;
            $display("FAIL wait_pos: position %0d not reached, actual %0d", p, m_t % FRAME);
        end
    endtask

    task automatic wr(input logic [15:0] d, input logic [3:0] dp, input int hold);
        wr_valid = 1'b1; wr_data = d; wr_dp = dp;
        cyc(hold);
        wr_valid = 1'b0;
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        cyc(2 * FRAME + 6);

        wait_pos(10);
        wr(16'h1234, 4'b0100, 1);
        cyc(3);
        wr(16'hFFFF, 4'hF, 5);
        cyc(FRAME + 4);

        wait_pos(FRAME - 1);
        wr(16'hABCD, 4'b1001, 1);
        cyc(2 * FRAME + 4);

        wait_pos(5);
        disp_en = 1'b0;
        cyc(40);
        disp_en = 1'b1;
        cyc(FRAME);

        wait_pos(3);
        wr(16'h0050, 4'b0000, 1);
        cyc(2 * FRAME);
        wait_pos(3);
        wr(16'h0000, 4'b0000, 1);
        cyc(2 * FRAME);

        wait_pos(3);
        wr(16'h5A5A, 4'b0011, 1);
        wait_pos(2 * SLOT + 4);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(FRAME + 4);

        repeat (400) begin
            wr_valid = ($urandom_range(0, 3) == 0);
            wr_data  = 16'($urandom);
            wr_dp    = 4'($urandom);
            if ($urandom_range(0, 31) == 0) disp_en = ~disp_en;
            cyc(1);
        end
        wr_valid = 1'b0;
        disp_en  = 1'b1;
        cyc(2 * FRAME + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
